// File: rtl/pci_pkg.sv
// PCI shared definitions: bus command codes and central-arbiter state encodings,
// common to the arbiter and the behavioural target/master models.
package pci_pkg;

    localparam logic [3:0] PCI_CMD_INT_ACK        = 4'h0;
    localparam logic [3:0] PCI_CMD_SPECIAL        = 4'h1;
    localparam logic [3:0] PCI_CMD_IO_READ        = 4'h2;
    localparam logic [3:0] PCI_CMD_IO_WRITE       = 4'h3;
    localparam logic [3:0] PCI_CMD_MEM_READ       = 4'h6;
    localparam logic [3:0] PCI_CMD_MEM_WRITE      = 4'h7;
    localparam logic [3:0] PCI_CMD_CFG_READ       = 4'hA;
    localparam logic [3:0] PCI_CMD_CFG_WRITE      = 4'hB;
    localparam logic [3:0] PCI_CMD_MEM_READ_MULT  = 4'hC;
    localparam logic [3:0] PCI_CMD_DUAL_ADDR      = 4'hD;
    localparam logic [3:0] PCI_CMD_MEM_READ_LINE  = 4'hE;
    localparam logic [3:0] PCI_CMD_MEM_WRITE_INV  = 4'hF;

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_GRANT,
        S_ARB_OWNED,
        S_ARB_GAP
    } arb_state_e;

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping,
// returned both one-hot and as an index.
module pci_rr_picker #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] onehot,
    output logic [IDX_W-1:0]       idx,
    output logic                   valid
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_MASTERS);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin REQ#/GNT# with a one-cycle gap between grants,
// hidden arbitration and idle-grant timeout. Define PCI_ARB_PARK_EN to park the idle bus.
module pci_bus_arbiter
    import pci_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned IDLE_TIMEOUT = 16,
    parameter int unsigned PARK_MASTER  = 0,
    localparam int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_n,
    output logic [NUM_MASTERS-1:0] gnt_n,
    input  logic                   frame_n,
    input  logic                   irdy_n,
    output logic [IDX_W-1:0]       owner,
    output logic                   owner_vld,
    output logic                   bus_idle,
    output logic                   timeout
);

`ifdef PCI_ARB_PARK_EN
    localparam bit PARK_EN = 1'b1;
`else
    localparam bit PARK_EN = 1'b0;
`endif

    localparam int unsigned      CNT_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       grantee_q, grantee_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] gnt_n_q, gnt_n_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic                   owner_vld_q, owner_vld_d;
    logic                   bus_idle_q;
    logic                   timeout_q, timeout_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_vld;
    logic                   start;
    logic                   cur_vld;
    logic [IDX_W-1:0]       cur_idx;
    logic [NUM_MASTERS-1:0] self_oh;
    logic                   others_req;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        if (32'(i) == NUM_MASTERS - 1) return '0;
        return i + IDX_W'(1);
    endfunction

    assign req   = ~req_n;
    assign start = bus_idle_q & ~frame_n;

    pci_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_vld)
    );

    // Which master currently sees its GNT# low (the one a start belongs to).
    always_comb begin
        cur_vld = 1'b0;
        cur_idx = grantee_q;
        self_oh = '0;
        self_oh[grantee_q] = 1'b1;
        if (state_q == S_ARB_GRANT || state_q == S_ARB_OWNED) begin
            cur_vld = 1'b1;
        end else if (state_q == S_ARB_IDLE && PARK_EN) begin
            cur_vld = 1'b1;
            cur_idx = PARK_IDX;
        end
        others_req = |(req & ~self_oh);
    end

    always_comb begin
        state_d   = state_q;
        grantee_d = grantee_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            S_ARB_IDLE: begin
                if (PARK_EN && start) begin
                    state_d   = S_ARB_OWNED;
                    grantee_d = PARK_IDX;
                end else if (win_vld) begin
                    // A parked grant may only move to another master through a gap.
                    if (!PARK_EN || win_idx == PARK_IDX) begin
                        state_d   = S_ARB_GRANT;
                        grantee_d = win_idx;
                        ptr_d     = inc_idx(win_idx);
                        cnt_d     = '0;
                    end else begin
                        state_d = S_ARB_GAP;
                    end
                end
            end
            S_ARB_GRANT: begin
                if (start) begin
                    state_d = S_ARB_OWNED;
                end else if (req_n[grantee_q]) begin
                    state_d = S_ARB_GAP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_ARB_GAP;
                    timeout_d = 1'b1;
                end else if (bus_idle_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ARB_OWNED: begin
                if (others_req || req_n[grantee_q]) state_d = S_ARB_GAP;
            end
            S_ARB_GAP: begin
                if (win_vld) begin
                    state_d   = S_ARB_GRANT;
                    grantee_d = win_idx;
                    ptr_d     = inc_idx(win_idx);
                    cnt_d     = '0;
                end else begin
                    state_d = S_ARB_IDLE;
                end
            end
            default: state_d = S_ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt_n_d = '1;
        if (state_d == S_ARB_GRANT || state_d == S_ARB_OWNED) begin
            gnt_n_d[grantee_d] = 1'b0;
        end else if (state_d == S_ARB_IDLE && PARK_EN) begin
            gnt_n_d[PARK_IDX] = 1'b0;
        end

        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        if (start && cur_vld) begin
            owner_d     = cur_idx;
            owner_vld_d = 1'b1;
        end else if (frame_n && irdy_n) begin
            owner_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ARB_IDLE;
            grantee_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_n_q     <= '1;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            bus_idle_q  <= 1'b1;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grantee_q   <= grantee_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_n_q     <= gnt_n_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            bus_idle_q  <= frame_n & irdy_n;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_n     = gnt_n_q;
    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign bus_idle  = bus_idle_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (N=4, IDLE_TIMEOUT=16, PARK_MASTER=0).
module tb_pci_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_n;
    logic [3:0] gnt_n;
    logic       frame_n;
    logic       irdy_n;
    logic [1:0] owner;
    logic       owner_vld;
    logic       bus_idle;
    logic       timeout;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [3:0] park_exp;

    pci_bus_arbiter #(
        .NUM_MASTERS  (4),
        .IDLE_TIMEOUT (16),
        .PARK_MASTER  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_n     (req_n),
        .gnt_n     (gnt_n),
        .frame_n   (frame_n),
        .irdy_n    (irdy_n),
        .owner     (owner),
        .owner_vld (owner_vld),
        .bus_idle  (bus_idle),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef PCI_ARB_PARK_EN
        park_exp = 4'b1110;
`else
        park_exp = 4'b1111;
`endif
        rst = 1'b1; req_n = 4'b1111; frame_n = 1'b1; irdy_n = 1'b1;
        #2;
        check("rst_gnt", 32'(gnt_n), 32'(4'b1111));
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_owner_vld", 32'(owner_vld), 32'd0);
        check("rst_bus_idle", 32'(bus_idle), 32'd1);
        check("rst_timeout", 32'(timeout), 32'd0);
        #10 rst = 1'b0;
        tick(); tick(); tick();
        check("idle_nopark", 32'(gnt_n), 32'(park_exp));

        // All masters request, single-phase transfers: grants 0,1,2,3,0 with gaps.
        req_n = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b1111;
            exp_g[k % 4] = 1'b0;
            check("rr_grant", 32'(gnt_n), 32'(exp_g));
            frame_n = 1'b0; irdy_n = 1'b0;
            tick();
            check("rr_owner", 32'(owner), 32'(k % 4));
            frame_n = 1'b1;
            tick();
            check("rr_gap", 32'(gnt_n), 32'(4'b1111));
            irdy_n = 1'b1;
            tick();
        end
        req_n = 4'b1111;
        tick(); tick();

        // Single requester 0, then start.
        req_n = 4'b1110;
        tick();
        check("t1_grant", 32'(gnt_n), 32'(4'b1110));
        frame_n = 1'b0;
        tick();
        check("t1_owner", 32'(owner), 32'd0);
        check("t1_owner_vld", 32'(owner_vld), 32'd1);
        check("t1_bus_busy", 32'(bus_idle), 32'd0);
        frame_n = 1'b1; irdy_n = 1'b0; req_n = 4'b1111;
        tick();
        check("t1_gap", 32'(gnt_n), 32'(4'b1111));
        check("t1_vld_hold", 32'(owner_vld), 32'd1);
        irdy_n = 1'b1;
        tick();
        check("t1_vld_clear", 32'(owner_vld), 32'd0);

        // Master 2 granted but idle: timeout after 16 clocks, then master 3.
        req_n = 4'b0011;
        tick();
        check("t3_grant", 32'(gnt_n), 32'(4'b1011));
        for (int i = 1; i < 16; i++) begin
            tick();
            check("t3_hold", 32'({timeout, gnt_n}), 32'({1'b0, 4'b1011}));
        end
        tick();
        check("t3_to_gnt", 32'(gnt_n), 32'(4'b1111));
        check("t3_to_pulse", 32'(timeout), 32'd1);
        tick();
        check("t3_next_gnt", 32'(gnt_n), 32'(4'b0111));
        check("t3_pulse_end", 32'(timeout), 32'd0);
        req_n = 4'b1111;
        tick(); tick();

        // Master 0 long burst, master 1 requests mid-burst (hidden arbitration).
        req_n = 4'b1110;
        tick();
        frame_n = 1'b0; irdy_n = 1'b0;
        tick();
        tick();
        req_n = 4'b1100;
        tick();
        check("t4_gap", 32'(gnt_n), 32'(4'b1111));
        tick();
        check("t4_hidden_gnt", 32'(gnt_n), 32'(4'b1101));
        check("t4_owner_still0", 32'({owner_vld, owner}), 32'({1'b1, 2'd0}));
        for (int i = 5; i < 20; i++) tick();
        frame_n = 1'b1;
        tick();
        check("t4_no_busy_count", 32'({timeout, gnt_n}), 32'({1'b0, 4'b1101}));
        irdy_n = 1'b1;
        tick();
        check("t4_idle", 32'({bus_idle, owner_vld}), 32'({1'b1, 1'b0}));
        frame_n = 1'b0; irdy_n = 1'b0;
        tick();
        check("t4_m1_start", 32'({owner_vld, owner}), 32'({1'b1, 2'd1}));

        // Asynchronous reset in mid-burst.
        #2 rst = 1'b1;
        #1;
        check("t5_gnt", 32'(gnt_n), 32'(4'b1111));
        check("t5_owner_vld", 32'(owner_vld), 32'd0);
        check("t5_owner", 32'(owner), 32'd0);
        frame_n = 1'b1; irdy_n = 1'b1; req_n = 4'b1111;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check("t6_idle_gnt", 32'(gnt_n), 32'(park_exp));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
